// File: rtl/seg7_multi_display_pkg.sv
// Shared types and constants for the multi-digit 7-segment display controller.
package seg7_pkg;

    // Width of one BCD digit / hex nibble.
    localparam int BCD_DIG_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    // Active-low glyphs, bit order g..a = bit6..bit0.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Entry n is the glyph for nibble n (0..9, A, b, C, d, E, F).
    localparam logic [15:0][6:0] GLYPH_TAB = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_multi_display_if.sv
// Request/status bundle between game logic (master) and the display controller (slave).
interface seg7_multi_display_if #(
    parameter int NUM_DIGITS = 3,
    parameter int DATA_W     = 7
);
    logic                    load;
    logic [DATA_W-1:0]       value;
    logic                    hex_mode;
    logic                    blank_lz;
    logic                    blink;
    logic                    busy;
    logic                    done;
    logic                    ovf;
    logic [7*NUM_DIGITS-1:0] seg;

    modport master (
        output load, value, hex_mode, blank_lz, blink,
        input  busy, done, ovf, seg
    );

    modport slave (
        input  load, value, hex_mode, blank_lz, blink,
        output busy, done, ovf, seg
    );
endinterface

// File: rtl/seg7_glyph_lut.sv
// Combinational nibble -> active-low 7-segment glyph decoder.
module seg7_glyph_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_TAB[nib];

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment controller: iterative double-dabble or hex nibble
// conversion, leading-zero blanking, overflow dashes and whole-display blink.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int DATA_W     = 7,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic               clk,
    input  logic               resetn,
    seg7_multi_display_if.slave bus
);

    localparam int BCD_W = BCD_DIG_W * (NUM_DIGITS + 1);
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int HEX_W = (DATA_W > 4 * NUM_DIGITS) ? DATA_W : 4 * NUM_DIGITS;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [7*NUM_DIGITS-1:0] ALL_BLANK = '1;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [SR_W-1:0]          sr;        // {BCD digits, binary being shifted out}
    logic                     hex_q;
    logic                     blz_q;
    logic                     carry_q;   // a 1 fell off the top of the BCD field
    logic                     busy_q;
    logic                     done_q;
    logic                     ovf_q;
    logic [7*NUM_DIGITS-1:0]  disp_q;    // stored digits, unaffected by blink
    logic [7*NUM_DIGITS-1:0]  seg_q;
    logic [BLK_W-1:0]         blk_cnt;
    logic                     blk_phase;

    logic [SR_W-1:0]                sr_adj;
    logic [HEX_W-1:0]               val_ext;
    logic [NUM_DIGITS-1:0][3:0]     nib;
    logic [NUM_DIGITS-1:0][6:0]     glyph;
    logic                           hex_over;
    logic                           over;
    logic [7*NUM_DIGITS-1:0]        new_disp;
    logic                           blk_wrap;
    logic                           phase_nx;

    // Double-dabble correction: add 3 to each BCD digit >= 5 before the shift.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < NUM_DIGITS + 1; d++) begin
            if (sr[DATA_W + 4*d +: 4] >= 4'd5)
                sr_adj[DATA_W + 4*d +: 4] = sr[DATA_W + 4*d +: 4] + 4'd3;
        end
    end

    // In hex mode the shift register still holds the raw value in its low bits.
    assign val_ext = HEX_W'(sr[DATA_W-1:0]);

    generate
        if (HEX_W > 4 * NUM_DIGITS) begin : g_hex_ovf
            assign hex_over = |val_ext[HEX_W-1:4*NUM_DIGITS];
        end else begin : g_hex_fit
            assign hex_over = 1'b0;
        end
    endgenerate

    // Select digit source per mode; the extra BCD digit or a lost carry flags overflow.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++)
            nib[k] = hex_q ? val_ext[4*k +: 4] : sr[DATA_W + 4*k +: 4];
        over = hex_q ? hex_over : (carry_q | (sr[SR_W-1 -: 4] != 4'd0));
    end

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
            seg7_glyph_lut u_lut (
                .nib   (nib[k]),
                .glyph (glyph[k])
            );
        end
    endgenerate

    // Compose the new display: dashes on overflow, else glyphs with leading-zero blanking.
    always_comb begin
        logic lead;
        new_disp = ALL_BLANK;
        lead     = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead = lead & (nib[k] == 4'd0);
            if (over)
                new_disp[7*k +: 7] = SEG_DASH;
            else if (blz_q && lead && (k != 0))
                new_disp[7*k +: 7] = SEG_BLANK;
            else
                new_disp[7*k +: 7] = glyph[k];
        end
    end

    // Conversion FSM: latch request, shift one bit per cycle, then publish.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            hex_q   <= 1'b0;
            blz_q   <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= ALL_BLANK;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        sr      <= {BCD_W'(0), bus.value};
                        hex_q   <= bus.hex_mode;
                        blz_q   <= bus.blank_lz;
                        carry_q <= 1'b0;
                        cnt     <= CNT_W'(DATA_W);
                        busy_q  <= 1'b1;
                        state   <= bus.hex_mode ? UPDATE : SHIFT;
                    end
                end
                SHIFT: begin
                    sr      <= {sr_adj[SR_W-2:0], 1'b0};
                    carry_q <= carry_q | sr_adj[SR_W-1];
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= UPDATE;
                end
                UPDATE: begin
                    disp_q <= new_disp;
                    ovf_q  <= over;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign blk_wrap = (blk_cnt == BLK_W'(BLINK_DIV - 1));
    assign phase_nx = bus.blink & (blk_wrap ? ~blk_phase : blk_phase);

    // Blink timebase; dropping blink clears it so the display reappears at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blk_cnt   <= '0;
            blk_phase <= 1'b0;
        end else if (!bus.blink) begin
            blk_cnt   <= '0;
            blk_phase <= 1'b0;
        end else begin
            blk_cnt   <= blk_wrap ? '0 : blk_cnt + 1'b1;
            blk_phase <= phase_nx;
        end
    end

    // Output register: new digits land with done; blink blanking is applied only here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            seg_q <= ALL_BLANK;
        else if (phase_nx)
            seg_q <= ALL_BLANK;
        else if (state == UPDATE)
            seg_q <= new_disp;
        else
            seg_q <= disp_q;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.seg  = seg_q;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed bench: a 3-digit and a 2-digit instance, hand-computed glyph expectations.
module tb_seg7_multi_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seg7_multi_display_if #(.NUM_DIGITS(3), .DATA_W(7)) bus_a ();
    seg7_multi_display_if #(.NUM_DIGITS(2), .DATA_W(7)) bus_b ();

    seg7_multi_display #(.NUM_DIGITS(3), .DATA_W(7), .BLINK_DIV(4)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a)
    );

    seg7_multi_display #(.NUM_DIGITS(2), .DATA_W(7), .BLINK_DIV(4)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b)
    );

    // Pulse load on one instance and wait (bounded) for done; lat=-1 on timeout.
    task automatic do_load(input bit b, input logic [6:0] v, input logic hx, input logic blz,
                           output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        if (b) begin
            bus_b.value = v; bus_b.hex_mode = hx; bus_b.blank_lz = blz; bus_b.load = 1'b1;
        end else begin
            bus_a.value = v; bus_a.hex_mode = hx; bus_a.blank_lz = blz; bus_a.load = 1'b1;
        end
        @(negedge clk);
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((b ? bus_b.done : bus_a.done) === 1'b1) begin
                lat = i;
                break;
            end
            if ((b ? bus_b.busy : bus_a.busy) === 1'b1) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus_a.load = 0; bus_a.value = '0; bus_a.hex_mode = 0; bus_a.blank_lz = 0; bus_a.blink = 0;
        bus_b.load = 0; bus_b.value = '0; bus_b.hex_mode = 0; bus_b.blank_lz = 0; bus_b.blink = 0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.seg !== 21'h1FFFFF) begin failures++; $display("FAIL reset_seg_a: got %h want 1fffff", bus_a.seg); end
        checks++;
        if (bus_b.seg !== 14'h3FFF) begin failures++; $display("FAIL reset_seg_b: got %h want 3fff", bus_b.seg); end
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.ovf} !== 3'b000)
            begin failures++; $display("FAIL reset_flags: got busy/done/ovf=%b want 000", {bus_a.busy, bus_a.done, bus_a.ovf}); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_decimal();
        int lat, bn;
        do_load(0, 7'd100, 0, 0, lat, bn);
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL dec100_latency: got %0d want 8", lat); end
        // 7 shift cycles followed by the update cycle
        checks++;
        if (bn !== 8) begin failures++; $display("FAIL dec100_busy_cycles: got %0d want 8", bn); end
        checks++;
        if (bus_a.seg !== {G1, G0, G0}) begin failures++; $display("FAIL dec100_seg: got %h want %h", bus_a.seg, {G1, G0, G0}); end
        checks++;
        if ({bus_a.ovf, bus_a.busy} !== 2'b00) begin failures++; $display("FAIL dec100_ovf_busy: got %b want 00", {bus_a.ovf, bus_a.busy}); end
    endtask

    task automatic test_blanking();
        int lat, bn;
        do_load(0, 7'd7, 0, 1, lat, bn);
        checks++;
        if (bus_a.seg !== {BL, BL, G7}) begin failures++; $display("FAIL blank7_seg: got %h want %h", bus_a.seg, {BL, BL, G7}); end
        do_load(0, 7'd0, 0, 1, lat, bn);
        checks++;
        if (bus_a.seg !== {BL, BL, G0}) begin failures++; $display("FAIL blank0_seg: got %h want %h", bus_a.seg, {BL, BL, G0}); end
    endtask

    task automatic test_hex();
        int lat, bn;
        do_load(0, 7'h7F, 1, 1, lat, bn);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL hex_latency: got %0d want 1", lat); end
        checks++;
        if (bus_a.seg !== {BL, G7, GF}) begin failures++; $display("FAIL hex7f_seg: got %h want %h", bus_a.seg, {BL, G7, GF}); end
        checks++;
        if (bus_a.ovf !== 1'b0) begin failures++; $display("FAIL hex7f_ovf: got %b want 0", bus_a.ovf); end
    endtask

    task automatic test_overflow();
        int lat, bn;
        do_load(1, 7'd100, 0, 0, lat, bn);
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL ovf_latency: got %0d want 8", lat); end
        checks++;
        if (bus_b.seg !== {DS, DS}) begin failures++; $display("FAIL ovf100_seg: got %h want %h", bus_b.seg, {DS, DS}); end
        checks++;
        if (bus_b.ovf !== 1'b1) begin failures++; $display("FAIL ovf100_flag: got %b want 1", bus_b.ovf); end
        do_load(1, 7'd99, 0, 1, lat, bn);
        checks++;
        if (bus_b.seg !== {G9, G9}) begin failures++; $display("FAIL ovf99_seg: got %h want %h", bus_b.seg, {G9, G9}); end
        checks++;
        if (bus_b.ovf !== 1'b0) begin failures++; $display("FAIL ovf99_flag: got %b want 0", bus_b.ovf); end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        do_load(0, 7'h12, 1, 1, lat, bn);
        // load presented in the done cycle must be accepted
        bus_a.value = 7'h34; bus_a.hex_mode = 1; bus_a.blank_lz = 1; bus_a.load = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        checks++;
        if ({bus_a.busy, bus_a.done} !== 2'b10) begin failures++; $display("FAIL b2b_accept: got busy/done=%b want 10", {bus_a.busy, bus_a.done}); end
        checks++;
        if (bus_a.seg !== {BL, G1, G2}) begin failures++; $display("FAIL b2b_hold: got %h want %h", bus_a.seg, {BL, G1, G2}); end
        @(negedge clk);
        checks++;
        if (bus_a.done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b want 1", bus_a.done); end
        checks++;
        if (bus_a.seg !== {BL, G3, G4}) begin failures++; $display("FAIL b2b_seg: got %h want %h", bus_a.seg, {BL, G3, G4}); end
    endtask

    task automatic test_blink();
        int lat, bn;
        logic [12:0] pat;
        logic [20:0] exp;
        do_load(0, 7'd5, 0, 1, lat, bn);
        checks++;
        if (bus_a.seg !== {BL, BL, G5}) begin failures++; $display("FAIL blink_pre_seg: got %h want %h", bus_a.seg, {BL, BL, G5}); end
        pat = 13'b1100001111000;   // bit e = 1 -> blanked after edge e of blinking
        bus_a.blink = 1'b1;
        for (int e = 0; e < 13; e++) begin
            @(negedge clk);
            exp = pat[e] ? 21'h1FFFFF : {BL, BL, G5};
            checks++;
            if (bus_a.seg !== exp) begin failures++; $display("FAIL blink_edge%0d: got %h want %h", e, bus_a.seg, exp); end
        end
        bus_a.blink = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.seg !== {BL, BL, G5}) begin failures++; $display("FAIL blink_off_seg: got %h want %h", bus_a.seg, {BL, BL, G5}); end
    endtask

    task automatic test_abort();
        int dones, done_at;
        dones = 0;
        done_at = -1;
        bus_a.value = 7'd42; bus_a.hex_mode = 0; bus_a.blank_lz = 1; bus_a.load = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus_a.done === 1'b1) begin dones++; done_at = i; end
            if (i == 2) begin bus_a.value = 7'd99; bus_a.load = 1'b1; end
            if (i == 3) bus_a.load = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin failures++; $display("FAIL busy_load_dones: got %0d want 1", dones); end
        checks++;
        if (done_at !== 8) begin failures++; $display("FAIL busy_load_done_at: got %0d want 8", done_at); end
        checks++;
        if (bus_a.seg !== {BL, G4, G2}) begin failures++; $display("FAIL dec42_seg: got %h want %h", bus_a.seg, {BL, G4, G2}); end
        // second conversion, aborted by reset partway through
        bus_a.value = 7'd55; bus_a.load = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (bus_a.seg !== 21'h1FFFFF) begin failures++; $display("FAIL abort_seg: got %h want 1fffff", bus_a.seg); end
        checks++;
        if ({bus_a.busy, bus_a.done} !== 2'b00) begin failures++; $display("FAIL abort_flags: got busy/done=%b want 00", {bus_a.busy, bus_a.done}); end
        @(negedge clk);
        resetn = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        checks++;
        if (bus_a.seg !== 21'h1FFFFF) begin failures++; $display("FAIL abort_seg_after: got %h want 1fffff", bus_a.seg); end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_blanking();
        test_hex();
        test_overflow();
        test_back_to_back();
        test_blink();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
